mac_kbd_device: RTL
===================

// Module: mac_kbd_device
// PURPOSE
//  Keyboard-end of the Mac Plus keyboard serial link: the device that owns the clock line.
//  Receives 8-bit commands from the VIA shift register and returns 8-bit responses.
//  Buffers scancodes from the PS/2 translator and answers Inquiry/Instant/Model/Test commands.
//  Sits between ps2_kbd (key source) and the VIA CB1/CB2 pins in dataController_top.
// PARAMETERS
//  CLK_HALF     1300        clk_en ticks per clock half-period (~162 us at 8 MHz)
//  INQ_TIMEOUT  2000000     clk_en ticks an Inquiry waits for a key before answering null (0.25 s)
//  MODEL_ID     8'h0B       byte returned to the Model command
//  FIFO_AW      2           key FIFO address width (depth = 2**FIFO_AW)
// PORTS
//  clk32       in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  clk_en      in   1  8 MHz tick enable; all state advances only when high
//  kbd_clk_o   out  1  keyboard clock to VIA CB1; idle high
//  kbd_dat_i   in   1  resolved data line as driven by the Mac (wired-AND, 1 = released)
//  kbd_dat_o   out  1  device drive of data line; 1 = released
//  key_strobe  in   1  one-tick pulse: key_code valid
//  key_code    in   8  Mac keyboard transition code
//  busy        out  1  high in any state except IDLE
//  overflow    out  1  sticky: key dropped on full FIFO; cleared by reset or Model command
// BEHAVIOUR
//  Reset: state IDLE, kbd_clk_o=1, kbd_dat_o=1, busy=0, overflow=0, FIFO empty, counters 0.
//  Bit timing: a bit = low half (CLK_HALF ticks, clk low) then high half (CLK_HALF ticks).
//   RX: device samples kbd_dat_i on the tick clk rises. TX: device updates kbd_dat_o on the
//   tick clk falls; MSB first both directions.
//  FSM:
//   IDLE: kbd_dat_i==0 sampled on a clk_en tick -> RX_CMD (bit count 0).
//   RX_CMD: 8 bit periods, kbd_dat_o=1; after 8th rising edge -> DECODE.
//   DECODE (1 tick): 8'h10 Inquiry: FIFO non-empty -> resp=pop, WAIT_HOST; else WAIT_KEY.
//    8'h14 Instant: resp = FIFO non-empty ? pop : 8'h7B. 8'h16 Model: resp=MODEL_ID,
//    flush FIFO, clear overflow. 8'h36 Test: resp=8'h7D. Any other: resp=8'h77.
//    All but Inquiry-empty -> WAIT_HOST.
//   WAIT_KEY: key arrives (FIFO non-empty) -> resp=pop, WAIT_HOST; timer reaches
//    INQ_TIMEOUT-1 -> resp=8'h7B, WAIT_HOST. Timer counts clk_en ticks, cleared on entry.
//   WAIT_HOST: clk held high, dat released; kbd_dat_i==1 -> TX_RESP.
//   TX_RESP: 8 bit periods driving resp; after 8th high half kbd_dat_o=1 -> IDLE.
//  FIFO: push on key_strobe when not full; full -> drop code, set overflow. Push and pop in
//   same tick both take effect (including full+pop: push accepted). Pointers wrap mod depth.
//   key_strobe accepted in every state, regardless of clk_en.
//  Data line low at IDLE is the only command start; a low kbd_dat_i during TX_RESP or
//   WAIT_KEY is ignored. Reset mid-transfer aborts immediately to reset values.
//  Counters: half-period counter width clog2(CLK_HALF); timeout width clog2(INQ_TIMEOUT).
// STRUCTURE
//  Package mac_kbd_pkg: command codes (INQUIRY 8'h10, INSTANT 8'h14, MODEL 8'h16,
//   TEST 8'h36), responses (NULL 8'h7B, ACK 8'h7D, NAK 8'h77), FSM state encoding.
//  Sub-module kbd_key_fifo: synchronous FIFO, params FIFO_AW; push/pop/flush, full/empty.
//  Top holds FSM, bit/half-period counters, shift register, inquiry timer.
// TESTING (bench uses CLK_HALF=4, INQ_TIMEOUT=200, clk_en every 4th clk32)
//  Mac sends 8'h16 then releases data -> response 8'h0B clocked out MSB first; FIFO flushed.
//  Push 8'h33, send 8'h10 -> response 8'h33 without waiting; FIFO empty after.
//  Send 8'h10 with empty FIFO, no key -> after 200 ticks in WAIT_KEY response 8'h7B.
//  Send 8'h10, push 8'h45 at tick 50 of WAIT_KEY -> response 8'h45, timer abandoned.
//  Push 5 codes into depth-4 FIFO -> overflow=1, Instant x4 returns first four, 5th gives 8'h7B.
//  Assert reset during TX_RESP bit 3 -> next tick kbd_clk_o=1, kbd_dat_o=1, busy=0.

Source files
------------

// File: rtl/mac_kbd_pkg.sv
// Shared command/response codes and FSM encoding for the Mac Plus keyboard-end link.
package mac_kbd_pkg;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;
    localparam logic [7:0] RSP_NAK     = 8'h77;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_CMD    = 3'd1,
        ST_DECODE    = 3'd2,
        ST_WAIT_KEY  = 3'd3,
        ST_WAIT_HOST = 3'd4,
        ST_TX_RESP   = 3'd5
    } kbdState_t;

endpackage

// File: rtl/kbd_key_fifo.sv
// Small synchronous FIFO for Mac transition codes; first-word-fall-through read.
module kbd_key_fifo #(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] pushData,
    output logic [7:0] rdData_c,
    output logic       full_c,
    output logic       empty_c
);

    localparam int unsigned PTR_W = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    // Full when the wrap bits differ but the addresses match; a pop frees the slot being written.
    always_comb begin
        empty_c  = (wrPtr == rdPtr);
        full_c   = (wrPtr[FIFO_AW] != rdPtr[FIFO_AW]) &&
                   (wrPtr[FIFO_AW-1:0] == rdPtr[FIFO_AW-1:0]);
        doPush   = push && (!full_c || pop);
        doPop    = pop && !empty_c;
        rdData_c = mem[rdPtr[FIFO_AW-1:0]];
    end

    // Pointer update; a flush coincident with a push keeps the new code.
    always_ff @(posedge clk32) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= push ? PTR_W'(1) : '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
        end
    end

    // Storage write, no reset needed on the data array.
    always_ff @(posedge clk32) begin
        if (!reset) begin
            if (flush && push) begin
                mem[0] <= pushData;
            end else if (!flush && doPush) begin
                mem[wrPtr[FIFO_AW-1:0]] <= pushData;
            end
        end
    end

endmodule

// File: rtl/mac_kbd_device.sv
// Keyboard end of the Mac Plus serial link: owns the clock, receives commands, returns responses.
module mac_kbd_device
    import mac_kbd_pkg::*;
#(
    parameter int unsigned CLK_HALF    = 1300,
    parameter int unsigned INQ_TIMEOUT = 2000000,
    parameter logic [7:0]  MODEL_ID    = 8'h0B,
    parameter int unsigned FIFO_AW     = 2
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       clk_en,
    output logic       kbd_clk_o,
    input  logic       kbd_dat_i,
    output logic       kbd_dat_o,
    input  logic       key_strobe,
    input  logic [7:0] key_code,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned HALF_W  = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int unsigned TIMER_W = (INQ_TIMEOUT > 1) ? $clog2(INQ_TIMEOUT) : 1;
    localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(CLK_HALF - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(INQ_TIMEOUT - 1);

    kbdState_t          state, stateNext;
    logic [HALF_W-1:0]  halfCnt, halfCntNext;
    logic [2:0]         bitCnt, bitCntNext;
    logic [7:0]         shiftReg, shiftNext;
    logic [TIMER_W-1:0] timer, timerNext;
    logic               clkNext;
    logic               datNext;
    logic               halfEnd;

    logic               fifoPop;
    logic               fifoFlush;
    logic [7:0]         fifoData;
    logic               fifoFull;
    logic               fifoEmpty;

    kbd_key_fifo #(.FIFO_AW(FIFO_AW)) uKeyFifo (
        .clk32    (clk32),
        .reset    (reset),
        .push     (key_strobe),
        .pop      (fifoPop),
        .flush    (fifoFlush),
        .pushData (key_code),
        .rdData_c (fifoData),
        .full_c   (fifoFull),
        .empty_c  (fifoEmpty)
    );

    // State and datapath registers; outputs are registered copies of the next values.
    always_ff @(posedge clk32) begin
        if (reset) begin
            state     <= ST_IDLE;
            halfCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            timer     <= '0;
            kbd_clk_o <= 1'b1;
            kbd_dat_o <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            halfCnt   <= halfCntNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftNext;
            timer     <= timerNext;
            kbd_clk_o <= clkNext;
            kbd_dat_o <= datNext;
            busy      <= (stateNext != ST_IDLE);
        end
    end

    // Sticky overflow: a key lost on a full FIFO; Model (flush) clears it.
    always_ff @(posedge clk32) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifoFlush) begin
            overflow <= 1'b0;
        end else if (key_strobe && fifoFull && !fifoPop) begin
            overflow <= 1'b1;
        end
    end

    // Next-state, bit timing and command decode; everything advances on clk_en ticks only.
    always_comb begin
        stateNext   = state;
        halfCntNext = halfCnt;
        bitCntNext  = bitCnt;
        shiftNext   = shiftReg;
        timerNext   = timer;
        clkNext     = kbd_clk_o;
        datNext     = kbd_dat_o;
        fifoPop     = 1'b0;
        fifoFlush   = 1'b0;
        halfEnd     = (halfCnt == HALF_LAST);

        if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    clkNext = 1'b1;
                    datNext = 1'b1;
                    if (!kbd_dat_i) begin
                        stateNext   = ST_RX_CMD;
                        halfCntNext = '0;
                        bitCntNext  = '0;
                        clkNext     = 1'b0;
                    end
                end

                ST_RX_CMD: begin
                    datNext = 1'b1;
                    if (halfEnd) begin
                        halfCntNext = '0;
                        if (!kbd_clk_o) begin
                            clkNext   = 1'b1;
                            shiftNext = {shiftReg[6:0], kbd_dat_i};
                            if (bitCnt == 3'd7) stateNext = ST_DECODE;
                        end else begin
                            clkNext    = 1'b0;
                            bitCntNext = bitCnt + 3'd1;
                        end
                    end else begin
                        halfCntNext = halfCnt + HALF_W'(1);
                    end
                end

                ST_DECODE: begin
                    stateNext = ST_WAIT_HOST;
                    case (shiftReg)
                        CMD_INQUIRY: begin
                            if (!fifoEmpty) begin
                                shiftNext = fifoData;
                                fifoPop   = 1'b1;
                            end else begin
                                stateNext = ST_WAIT_KEY;
                                timerNext = '0;
                            end
                        end
                        CMD_INSTANT: begin
                            shiftNext = fifoEmpty ? RSP_NULL : fifoData;
                            fifoPop   = !fifoEmpty;
                        end
                        CMD_MODEL: begin
                            shiftNext = MODEL_ID;
                            fifoFlush = 1'b1;
                        end
                        CMD_TEST:  shiftNext = RSP_ACK;
                        default:   shiftNext = RSP_NAK;
                    endcase
                end

                ST_WAIT_KEY: begin
                    if (!fifoEmpty) begin
                        shiftNext = fifoData;
                        fifoPop   = 1'b1;
                        stateNext = ST_WAIT_HOST;
                    end else if (timer == TIMER_LAST) begin
                        shiftNext = RSP_NULL;
                        stateNext = ST_WAIT_HOST;
                    end else begin
                        timerNext = timer + TIMER_W'(1);
                    end
                end

                ST_WAIT_HOST: begin
                    clkNext = 1'b1;
                    datNext = 1'b1;
                    if (kbd_dat_i) begin
                        stateNext   = ST_TX_RESP;
                        halfCntNext = '0;
                        bitCntNext  = '0;
                        clkNext     = 1'b0;
                        datNext     = shiftReg[7];
                        shiftNext   = {shiftReg[6:0], 1'b0};
                    end
                end

                ST_TX_RESP: begin
                    if (halfEnd) begin
                        halfCntNext = '0;
                        if (!kbd_clk_o) begin
                            clkNext = 1'b1;
                        end else if (bitCnt == 3'd7) begin
                            stateNext = ST_IDLE;
                            datNext   = 1'b1;
                        end else begin
                            clkNext    = 1'b0;
                            datNext    = shiftReg[7];
                            shiftNext  = {shiftReg[6:0], 1'b0};
                            bitCntNext = bitCnt + 3'd1;
                        end
                    end else begin
                        halfCntNext = halfCnt + HALF_W'(1);
                    end
                end

                default: stateNext = ST_IDLE;
            endcase
        end
    end

endmodule
